// File: rtl/demux_8_pkg.sv
// Shared types and sizes for the 8-way write demux register bank.
// Register count, select width and the select/one-hot types.
package demux_8_pkg;

    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_OUT-1:0] onehot_t;

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable.
// Produces per-register write enables; all zero when disabled.
module decoder_3to8
    import demux_8_pkg::*;
(
    input  sel_t    sel,
    input  logic    en,
    output onehot_t onehot
);

    // One bit set at the selected index when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_8_reg_bank.sv
// Write-side 8-way register bank with a pending/skid write buffer.
// Optional ZERO_REG_EN: register 0 reads as zero and never commits.
module demux_8_reg_bank
    import demux_8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  sel_t                     wr_sel,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     hold,
    output logic [NUM_OUT*WIDTH-1:0] q_flat,
    output onehot_t                  wr_onehot
);

    logic             p_valid;
    sel_t             p_sel;
    logic [WIDTH-1:0] p_data;
    logic             s_valid;
    sel_t             s_sel;
    logic [WIDTH-1:0] s_data;

    logic [WIDTH-1:0] regs [NUM_OUT];

    logic    accept;
    logic    commit;
    logic    commit_en;
    onehot_t we;

    // Skid slot full means no room for another write
    assign wr_ready = rst_n & ~s_valid;
    assign accept   = wr_valid & wr_ready;
    assign commit   = p_valid & ~hold;

`ifdef ZERO_REG_EN
    assign commit_en = commit & (p_sel != '0);
`else
    assign commit_en = commit;
`endif

    decoder_3to8 u_dec (
        .sel    (p_sel),
        .en     (commit_en),
        .onehot (we)
    );

    // Pending/skid buffer: in-order two-entry queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_sel   <= '0;
            p_data  <= '0;
            s_valid <= 1'b0;
            s_sel   <= '0;
            s_data  <= '0;
        end else if (commit || !p_valid) begin
            if (s_valid) begin
                p_valid <= 1'b1;
                p_sel   <= s_sel;
                p_data  <= s_data;
                s_valid <= 1'b0;
            end else if (accept) begin
                p_valid <= 1'b1;
                p_sel   <= wr_sel;
                p_data  <= wr_data;
            end else begin
                p_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_sel   <= wr_sel;
            s_data  <= wr_data;
        end
    end

    // Register file update and commit pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                regs[i] <= '0;
            end
            wr_onehot <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (we[i]) begin
                    regs[i] <= p_data;
                end
            end
            wr_onehot <= we;
        end
    end

    // Flatten registers for the downstream read muxes
    always_comb begin
        q_flat = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            q_flat[i*WIDTH +: WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_demux_8_reg_bank.sv
// Self-checking bench for demux_8_reg_bank.
// Reference model: a 2-deep write queue plus an array of 8 registers.
module tb_demux_8_reg_bank;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_sel;
    logic [31:0]  wr_data;
    logic         hold;
    logic [255:0] q_flat;
    logic [7:0]   wr_onehot;

    always #5 clk = ~clk;

    demux_8_reg_bank #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .hold      (hold),
        .q_flat    (q_flat),
        .wr_onehot (wr_onehot)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] data;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mregs [8];
    wr_t         mq [$];
    logic [7:0]  monehot;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = mregs[i];
        return f;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        monehot = '0;
    endtask

    // One clock: drive at negedge, check ready, update model at posedge,
    // check state just after the edge, return at next negedge.
    task automatic cycle(input logic v, input logic [2:0] s,
                         input logic [31:0] d, input logic h);
        logic acc;
        wr_t  w;
        wr_valid = v;
        wr_sel   = s;
        wr_data  = d;
        hold     = h;
        #1;
        check("wr_ready", {255'd0, wr_ready}, {255'd0, mq.size() < 2});
        check("q_pre", q_flat, model_flat());
        @(posedge clk);
        acc = v && (mq.size() < 2);
        monehot = '0;
        if (mq.size() > 0 && !h) begin
            w = mq.pop_front();
`ifdef ZERO_REG_EN
            if (w.sel != 3'd0) begin
                mregs[w.sel] = w.data;
                monehot = 8'd1 << w.sel;
            end
`else
            mregs[w.sel] = w.data;
            monehot = 8'd1 << w.sel;
`endif
        end
        if (acc) begin
            w.sel  = s;
            w.data = d;
            mq.push_back(w);
        end
        #1;
        check("wr_onehot", {248'd0, wr_onehot}, {248'd0, monehot});
        check("q_flat", q_flat, model_flat());
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        hold     = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_q", q_flat, 256'd0);
        check("rst_onehot", {248'd0, wr_onehot}, 256'd0);
        check("rst_ready", {255'd0, wr_ready}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write to reg 5
        cycle(1'b1, 3'd5, 32'hDEADBEEF, 1'b0);
        cycle(1'b0, 3'd0, 32'h0, 1'b0);
        check("t2_reg5", {224'd0, q_flat[5*32 +: 32]}, {224'd0, 32'hDEADBEEF});
        check("t2_onehot", {248'd0, wr_onehot}, {248'd0, 8'h20});
        cycle(1'b0, 3'd0, 32'h0, 1'b0);

        // Backpressure with hold
        cycle(1'b1, 3'd1, 32'hA1, 1'b1);
        cycle(1'b1, 3'd2, 32'hA2, 1'b1);
        cycle(1'b1, 3'd3, 32'hA3, 1'b1);
        check("t3_stall", {255'd0, wr_ready}, 256'd0);
        cycle(1'b1, 3'd3, 32'hA3, 1'b0);
        check("t3_oh1", {248'd0, wr_onehot}, {248'd0, 8'h02});
        cycle(1'b1, 3'd3, 32'hA3, 1'b0);
        check("t3_oh2", {248'd0, wr_onehot}, {248'd0, 8'h04});
        cycle(1'b0, 3'd0, 32'h0, 1'b0);
        check("t3_oh3", {248'd0, wr_onehot}, {248'd0, 8'h08});
        check("t3_regs", {160'd0, q_flat[32 +: 96]},
              {160'd0, 32'hA3, 32'hA2, 32'hA1});

        // Same target back-to-back
        cycle(1'b1, 3'd4, 32'h11, 1'b0);
        cycle(1'b1, 3'd4, 32'h22, 1'b0);
        cycle(1'b0, 3'd0, 32'h0, 1'b0);
        cycle(1'b0, 3'd0, 32'h0, 1'b0);
        check("t4_reg4", {224'd0, q_flat[4*32 +: 32]}, {224'd0, 32'h22});

        // Reg 0 write
        cycle(1'b1, 3'd0, 32'hFFFF, 1'b0);
        cycle(1'b0, 3'd0, 32'h0, 1'b0);
`ifdef ZERO_REG_EN
        check("t6_reg0", {224'd0, q_flat[31:0]}, 256'd0);
        check("t6_onehot", {248'd0, wr_onehot}, 256'd0);
`else
        check("t6_reg0", {224'd0, q_flat[31:0]}, {224'd0, 32'hFFFF});
        check("t6_onehot", {248'd0, wr_onehot}, {248'd0, 8'h01});
`endif

        // Reset mid-operation with P and S full
        cycle(1'b1, 3'd6, 32'h66, 1'b1);
        cycle(1'b1, 3'd7, 32'h77, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_q", q_flat, 256'd0);
        check("t5_ready", {255'd0, wr_ready}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 9) < 3));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
